// File: rtl/key_evt_if.sv
// Key event / LED bundle between the key filters,
// the event scheduler and the LED pins.
interface key_evt_if;
  logic       key_flag0;
  logic       key_state0;
  logic       key_flag1;
  logic       key_state1;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       evt_drop;

  modport master (
    output key_flag0, key_state0,
    output key_flag1, key_state1,
    input  led, mode, speed, evt_drop
  );

  modport slave (
    input  key_flag0, key_state0,
    input  key_flag1, key_state1,
    output led, mode, speed, evt_drop
  );
endinterface

// File: rtl/key_evt_sched.sv
// Key event scheduler: latches presses, arbitrates
// them round-robin and drives the LED pattern engine.
module key_evt_sched #(
  parameter int TICK_BASE = 12_500_000,
  parameter int CNT_W     = 24
) (
  input logic      clk,
  input logic      rst,
  key_evt_if.slave bus
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_APPLY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] BASE =
    CNT_W'(TICK_BASE);

  state_t           state;
  logic [1:0]       pend;
  logic             rr;
  logic             gsel;
  logic [CNT_W-1:0] tick_cnt;
  logic [3:0]       led_q;
  logic [1:0]       mode_q;
  logic [1:0]       speed_q;
  logic             drop_q;

  logic [1:0]       press;
  logic [1:0]       gmask;
  logic [1:0]       drop;
  logic [1:0]       pend_n;
  logic             grant;
  logic             gkey;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] last;

  function automatic logic [3:0] entry_pat(
    input logic [1:0] m
  );
    logic [3:0] p;
    p = 4'b0000;
    unique case (m)
      2'd1:    p = 4'b0001;
      2'd2:    p = 4'b1111;
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] next_pat(
    input logic [1:0] m,
    input logic [3:0] l
  );
    logic [3:0] p;
    p = l;
    unique case (m)
      2'd0: p = 4'b0000;
      2'd1: p = {l[2:0], l[3]};
      2'd2: p = ~l;
      2'd3: p = l + 4'd1;
    endcase
    return p;
  endfunction

  // Press decode, arbitration, overflow and tick detect
  always_comb begin
    press = {bus.key_flag1 & ~bus.key_state1,
             bus.key_flag0 & ~bus.key_state0};
    grant = (state == S_RUN) && (pend != 2'b00);
    gkey  = (pend == 2'b11) ? rr : pend[1];
    gmask = 2'b00;
    if (grant)
      gmask = gkey ? 2'b10 : 2'b01;
    drop   = press & pend & ~gmask;
    pend_n = (pend & ~gmask) | press;
    period = BASE >> speed_q;
    last   = period - CNT_W'(1);
    tick   = (state == S_RUN) && (tick_cnt == last);
  end

  // Sequencer FSM with timer, pattern engine and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      pend     <= 2'b00;
      rr       <= 1'b0;
      gsel     <= 1'b0;
      tick_cnt <= '0;
      led_q    <= 4'b0000;
      mode_q   <= 2'd0;
      speed_q  <= 2'd0;
      drop_q   <= 1'b0;
    end else begin
      pend   <= pend_n;
      drop_q <= |drop;
      unique case (state)
        S_RUN: begin
          if (tick) begin
            tick_cnt <= '0;
            led_q    <= next_pat(mode_q, led_q);
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
          if (grant) begin
            gsel  <= gkey;
            state <= S_APPLY;
            if (pend == 2'b11)
              rr <= ~rr;
          end
        end
        S_APPLY: begin
          tick_cnt <= '0;
          if (!gsel) begin
            mode_q <= mode_q + 2'd1;
            led_q  <= entry_pat(mode_q + 2'd1);
          end else begin
            speed_q <= speed_q + 2'd1;
          end
          state <= S_RUN;
        end
      endcase
    end
  end

  assign bus.led      = led_q;
  assign bus.mode     = mode_q;
  assign bus.speed    = speed_q;
  assign bus.evt_drop = drop_q;

endmodule

// File: tb/tb_key_evt_sched.sv
// Randomized and directed bench for key_evt_sched
// against an event-level reference model.
module tb_key_evt_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_evt_if bus();

  key_evt_sched #(
    .TICK_BASE(8),
    .CNT_W    (24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit m_pend [2];
  bit m_rr;
  bit m_apply;
  bit m_gsel;
  bit m_drop;
  int m_mode;
  int m_speed;
  int m_base;
  int m_runs;

  function automatic int entry(input int m);
    if (m == 1) return 1;
    if (m == 2) return 15;
    return 0;
  endfunction

  // LED from the entry/base value and ticks since base
  function automatic int m_led();
    int k;
    int r;
    k = m_runs / (8 >> m_speed);
    case (m_mode)
      1: begin
        r = k % 4;
        return ((m_base << r) | (m_base >> (4 - r))) & 15;
      end
      2: return (k % 2) ? (~m_base) & 15 : m_base;
      3: return (m_base + k) % 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [8:0] exp_vec();
    return {4'(m_led()), 2'(m_mode), 2'(m_speed), m_drop};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.led, bus.mode, bus.speed, bus.evt_drop};
  endfunction

  task automatic model_update(
    input bit f0, input bit s0,
    input bit f1, input bit s1,
    input bit r
  );
    bit p [2];
    bit both;
    bit grant;
    bit g;
    bit dn;
    p[0] = f0 && !s0;
    p[1] = f1 && !s1;
    if (r) begin
      m_pend[0] = 0; m_pend[1] = 0;
      m_rr = 0; m_apply = 0; m_gsel = 0; m_drop = 0;
      m_mode = 0; m_speed = 0; m_base = 0; m_runs = 0;
      return;
    end
    both  = m_pend[0] && m_pend[1];
    grant = !m_apply && (m_pend[0] || m_pend[1]);
    g     = both ? m_rr : m_pend[1];
    dn    = 0;
    for (int i = 0; i < 2; i++)
      if (p[i] && m_pend[i] && !(grant && int'(g) == i))
        dn = 1;
    if (grant) begin
      m_pend[int'(g)] = 0;
      if (both) m_rr = !m_rr;
    end
    for (int i = 0; i < 2; i++)
      if (p[i]) m_pend[i] = 1;
    if (m_apply) begin
      if (!m_gsel) begin
        m_mode = (m_mode + 1) % 4;
        m_base = entry(m_mode);
      end else begin
        m_base  = m_led();
        m_speed = (m_speed + 1) % 4;
      end
      m_runs  = 0;
      m_apply = 0;
    end else begin
      m_runs++;
      if (grant) begin
        m_apply = 1;
        m_gsel  = g;
      end
    end
    m_drop = dn;
  endtask

  // drive one cycle, advance model, land 1ns past the edge
  task automatic step(
    input bit f0, input bit s0,
    input bit f1, input bit s1,
    input bit r
  );
    @(negedge clk);
    rst            = r;
    bus.key_flag0  = f0;
    bus.key_state0 = s0;
    bus.key_flag1  = f1;
    bus.key_state1 = s1;
    model_update(f0, s0, f1, s1, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 1, 0, 1, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 1);
      n_chk++;
      if (obs() !== 9'h000)
        $display("FAIL reset_hold got=%h exp=%h", obs(), 9'h000);
      else n_pass++;
    end
    for (int i = 0; i < 12; i++) begin
      idle();
      n_chk++;
      if (obs() !== 9'h000)
        $display("FAIL reset_idle got=%h exp=%h", obs(), 9'h000);
      else n_pass++;
    end
  endtask

  task automatic test_mode_step();
    step(1, 0, 0, 1, 0);
    idle();
    idle();
    n_chk++;
    if ({bus.mode, bus.led} !== {2'd1, 4'b0001})
      $display("FAIL mode_entry got=%h exp=%h",
               {bus.mode, bus.led}, {2'd1, 4'b0001});
    else n_pass++;
    for (int i = 1; i <= 32; i++) begin
      idle();
      n_chk++;
      if (obs() !== exp_vec())
        $display("FAIL run_model got=%h exp=%h", obs(), exp_vec());
      else n_pass++;
      if (i == 8) begin
        n_chk++;
        if (bus.led !== 4'b0010)
          $display("FAIL run_step got=%b exp=0010", bus.led);
        else n_pass++;
      end
      if (i == 32) begin
        n_chk++;
        if (bus.led !== 4'b0001)
          $display("FAIL run_wrap got=%b exp=0001", bus.led);
        else n_pass++;
      end
    end
  endtask

  task automatic test_speed();
    step(0, 1, 1, 0, 0);
    idle();
    idle();
    n_chk++;
    if ({bus.mode, bus.speed} !== {2'd1, 2'd1})
      $display("FAIL speed_one got=%h exp=%h",
               {bus.mode, bus.speed}, {2'd1, 2'd1});
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      idle();
      n_chk++;
      if (obs() !== exp_vec())
        $display("FAIL speed1_model got=%h exp=%h", obs(), exp_vec());
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 0, 0);
      idle();
      idle();
    end
    n_chk++;
    if (bus.speed !== 2'd0)
      $display("FAIL speed_wrap got=%0d exp=0", bus.speed);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      idle();
      n_chk++;
      if (obs() !== exp_vec())
        $display("FAIL speed0_model got=%h exp=%h", obs(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] m0;
    logic [1:0] s0;
    for (int rep = 0; rep < 2; rep++) begin
      m0 = 2'(m_mode);
      s0 = 2'(m_speed);
      step(1, 0, 1, 0, 0);
      idle();
      idle();
      n_chk++;
      if (rep == 0 && {bus.mode, bus.speed} !== {m0 + 2'd1, s0} ||
          rep == 1 && {bus.mode, bus.speed} !== {m0, s0 + 2'd1})
        $display("FAIL simul_first rep=%0d got=%h m0=%0d s0=%0d",
                 rep, {bus.mode, bus.speed}, m0, s0);
      else n_pass++;
      idle();
      idle();
      n_chk++;
      if ({bus.mode, bus.speed} !== {m0 + 2'd1, s0 + 2'd1})
        $display("FAIL simul_second got=%h exp=%h",
                 {bus.mode, bus.speed}, {m0 + 2'd1, s0 + 2'd1});
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        idle();
        n_chk++;
        if (obs() !== exp_vec())
          $display("FAIL simul_model got=%h exp=%h", obs(), exp_vec());
        else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    logic [1:0] m0;
    logic [1:0] s0;
    m0 = 2'(m_mode);
    s0 = 2'(m_speed);
    step(1, 0, 1, 0, 0);
    n_chk++;
    if (bus.evt_drop !== 1'b0)
      $display("FAIL drop_early got=%b exp=0", bus.evt_drop);
    else n_pass++;
    step(0, 1, 1, 0, 0);
    n_chk++;
    if (bus.evt_drop !== 1'b1)
      $display("FAIL drop_pulse got=%b exp=1", bus.evt_drop);
    else n_pass++;
    idle();
    n_chk++;
    if (bus.evt_drop !== 1'b0)
      $display("FAIL drop_len got=%b exp=0", bus.evt_drop);
    else n_pass++;
    for (int i = 0; i < 6; i++) idle();
    n_chk++;
    if ({bus.mode, bus.speed} !== {m0 + 2'd1, s0 + 2'd1})
      $display("FAIL drop_result got=%h exp=%h",
               {bus.mode, bus.speed}, {m0 + 2'd1, s0 + 2'd1});
    else n_pass++;
  endtask

  task automatic test_mode_cycle();
    logic [1:0] mt [4];
    logic [3:0] lt [4];
    mt = '{2'd1, 2'd2, 2'd3, 2'd0};
    lt = '{4'b0001, 4'b1111, 4'b0000, 4'b0000};
    step(0, 1, 0, 1, 1);
    idle();
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 1, 0);
      idle();
      idle();
      n_chk++;
      if ({bus.mode, bus.led} !== {mt[k], lt[k]})
        $display("FAIL mode_seq k=%0d got=%h exp=%h",
                 k, {bus.mode, bus.led}, {mt[k], lt[k]});
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 1, 0);
      n_chk++;
      if (obs() !== exp_vec() || bus.mode !== 2'd0)
        $display("FAIL release got=%h exp=%h", obs(), exp_vec());
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1, 0);
      idle();
      idle();
    end
    for (int i = 1; i <= 128; i++) begin
      idle();
      if (i == 120) begin
        n_chk++;
        if ({bus.mode, bus.led} !== {2'd3, 4'hf})
          $display("FAIL count_top got=%h exp=%h",
                   {bus.mode, bus.led}, {2'd3, 4'hf});
        else n_pass++;
      end
    end
    n_chk++;
    if ({bus.mode, bus.led} !== {2'd3, 4'h0})
      $display("FAIL count_wrap got=%h exp=%h",
               {bus.mode, bus.led}, {2'd3, 4'h0});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1, 0);
      idle();
      idle();
    end
    for (int i = 0; i < 11; i++) idle();
    step(1, 0, 1, 0, 1);
    n_chk++;
    if (obs() !== 9'h000)
      $display("FAIL reset_blink got=%h exp=%h", obs(), 9'h000);
    else n_pass++;
  endtask

  task automatic test_random();
    bit f0, s0, f1, s1, r;
    for (int i = 0; i < 800; i++) begin
      f0 = ($urandom_range(0, 3) == 0);
      f1 = ($urandom_range(0, 3) == 0);
      s0 = ($urandom_range(0, 2) == 0);
      s1 = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(f0, s0, f1, s1, r);
      n_chk++;
      if (obs() !== exp_vec())
        $display("FAIL random cyc=%0d got=%h exp=%h",
                 i, obs(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    bus.key_flag0  = 1'b0;
    bus.key_state0 = 1'b1;
    bus.key_flag1  = 1'b0;
    bus.key_state1 = 1'b1;
    test_reset();
    test_mode_step();
    test_speed();
    test_simultaneous();
    test_overflow();
    test_mode_cycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
